// File: rtl/lcd_cmd_engine_pkg.sv
// Shared definitions for the HD44780 command engine: FSM states, dataa bit map,
// LCD command codes and the layout of the status word returned in result.
package lcd_cmd_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_DONE
  } state_t;

  localparam int RS_BIT   = 0;
  localparam int LONG_BIT = 1;
  localparam int NIB_BIT  = 2;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  localparam int RES_TXN_LSB  = 16;
  localparam int RES_BYTE_LSB = 8;
  localparam int RES_OK_BIT   = 0;

  // Clear (0x01) and both home encodings (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
    return !rs && ((cmd == LCD_CLEAR) || (cmd[7:1] == LCD_HOME[7:1]));
  endfunction

  function automatic logic [31:0] make_result(input logic [15:0] txn, input logic [7:0] cmd);
    logic [31:0] r;
    r = '0;
    r[RES_TXN_LSB +: 16] = txn;
    r[RES_BYTE_LSB +: 8] = cmd;
    r[RES_OK_BIT]        = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_cmd_engine_if.sv
// Nios II custom-instruction handshake: the CPU side is the master, the engine the slave.
interface lcd_cmd_engine_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, output start, output dataa, output datab,
                  input result, input done);
  modport slave  (input clk_en, input start, input dataa, input datab,
                  output result, output done);
endinterface

// File: rtl/lcd_cmd_engine_delay_counter.sv
// Reloadable down-counter; expire is high during the last enabled cycle of a phase.
module lcd_delay_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic             busy;

  // Loading N makes expire fire in the N-th enabled cycle after the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= load_val - CNT_W'(1);
      busy  <= 1'b1;
    end else if (enable && busy) begin
      if (count == '0) begin
        busy <= 1'b0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign expire = enable && busy && (count == '0);

endmodule

// File: rtl/lcd_cmd_engine.sv
// HD44780 command/data engine run as a multi-cycle Nios II custom instruction,
// sequencing setup, enable pulse, hold and execution wait for 8- or 4-bit buses.
module lcd_cmd_engine
  import lcd_cmd_engine_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 82000,
  parameter int CNT_W       = 20
) (
  input  logic              clk,
  input  logic              reset,
  lcd_cmd_engine_if.slave   ci,
  output logic              rs,
  output logic              rw,
  output logic              en,
  output logic [7:0]        db
);

  if (!(BUS_WIDTH == 8 || BUS_WIDTH == 4)) begin : g_bad_bus_width
    $error("lcd_cmd_engine: BUS_WIDTH must be 8 or 4");
  end

  if (T_SETUP_CYC < 1 || T_EN_CYC < 1 || T_HOLD_CYC < 1 || T_EXEC_CYC < 1 || T_LONG_CYC < 1
      || T_LONG_CYC >= (64'd1 << CNT_W) || T_EXEC_CYC >= (64'd1 << CNT_W)
      || T_EN_CYC >= (64'd1 << CNT_W)) begin : g_bad_timing
    $error("lcd_cmd_engine: timing parameters must be >= 1 and fit in CNT_W bits");
  end

  localparam bit IS_4BIT = (BUS_WIDTH == 4);

  state_t           state;
  state_t           state_nx;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_expire;
  logic             accept;
  logic             next_nibble;
  logic             finish;

  logic             rs_q;
  logic [7:0]       db_q;
  logic [7:0]       byte_q;
  logic             long_q;
  logic             nib_only;
  logic             hi_phase;
  logic [15:0]      txn_count;
  logic [31:0]      result_q;
  logic             unused_bits;

  assign unused_bits = ^{ci.dataa[31:3], ci.datab[31:8]};

  lcd_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .enable  (ci.clk_en),
    .load    (cnt_load),
    .load_val(cnt_val),
    .expire  (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Every phase change reloads the shared counter with the next phase length.
  always_comb begin
    state_nx    = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    accept      = 1'b0;
    next_nibble = 1'b0;
    finish      = 1'b0;
    if (ci.clk_en) begin
      case (state)
        ST_IDLE: begin
          if (ci.start) begin
            accept   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_SETUP_CYC);
            state_nx = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_expire) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_EN_CYC);
            state_nx = ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt_expire) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_HOLD_CYC);
            state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_expire) begin
            cnt_load = 1'b1;
            if (IS_4BIT && hi_phase && !nib_only) begin
              next_nibble = 1'b1;
              cnt_val     = CNT_W'(T_SETUP_CYC);
              state_nx    = ST_SETUP;
            end else begin
              cnt_val  = long_q ? CNT_W'(T_LONG_CYC) : CNT_W'(T_EXEC_CYC);
              state_nx = ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_expire) begin
            finish   = 1'b1;
            state_nx = ST_DONE;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // In 4-bit mode the high nibble goes out first on db[7:4]; db[3:0] stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q      <= 1'b0;
      db_q      <= '0;
      byte_q    <= '0;
      long_q    <= 1'b0;
      nib_only  <= 1'b0;
      hi_phase  <= 1'b0;
      txn_count <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        rs_q     <= ci.dataa[RS_BIT];
        byte_q   <= ci.datab[7:0];
        long_q   <= ci.dataa[LONG_BIT] | is_long_cmd(ci.dataa[RS_BIT], ci.datab[7:0]);
        nib_only <= IS_4BIT && ci.dataa[NIB_BIT];
        hi_phase <= IS_4BIT;
        db_q     <= IS_4BIT ? {ci.datab[7:4], 4'h0} : ci.datab[7:0];
      end
      if (next_nibble) begin
        db_q     <= {byte_q[3:0], 4'h0};
        hi_phase <= 1'b0;
      end
      if (finish) begin
        txn_count <= txn_count + 16'd1;
        result_q  <= make_result(txn_count + 16'd1, byte_q);
      end
    end
  end

  assign en        = (state == ST_PULSE);
  assign ci.done   = (state == ST_DONE);
  assign ci.result = result_q;
  assign rs        = rs_q;
  assign db        = db_q;
  assign rw        = 1'b0;

endmodule
